// File: rtl/serial_cmp_pkg.sv
// Shared types for the MSB-first serial compare controller and its comparator.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } cmp_state_t;

  typedef struct packed {
    logic less;
    logic eq;
    logic greater;
  } cmp_result_t;

  // Down-counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned w);
    return ($clog2(w) > 0) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_comparator_most_significant_first.sv
// Bit-serial unsigned comparator fed MSB first; the first differing bit decides.
module serial_comparator_most_significant_first
  import serial_cmp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        a,
  input  logic        b,
  output cmp_result_t result_c
);

  logic lt_q;
  logic gt_q;
  logic lt_n;
  logic gt_n;
  logic decided;

  // Result including the bit currently presented, so the controller can latch it this cycle.
  always_comb begin
    decided         = lt_q | gt_q;
    lt_n            = lt_q | (en & ~decided & ~a & b);
    gt_n            = gt_q | (en & ~decided & a & ~b);
    result_c.less    = lt_n;
    result_c.eq      = ~(lt_n | gt_n);
    result_c.greater = gt_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lt_q <= 1'b0;
      gt_q <= 1'b0;
    end else begin
      lt_q <= lt_n;
      gt_q <= gt_n;
    end
  end

endmodule

// File: rtl/serial_compare_controller.sv
// Accepts a parallel operand pair, shifts it MSB first through a serial comparator,
// and returns a one-hot less/eq/greater result over valid/ready.
module serial_compare_controller
  import serial_cmp_pkg::*;
#(
  parameter int unsigned W          = 8,
  parameter bit          EARLY_EXIT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_a,
  input  logic [W-1:0] up_b,
  output logic         down_valid,
  input  logic         down_ready,
  output logic         down_less,
  output logic         down_eq,
  output logic         down_greater,
  output logic         busy
);

  localparam int unsigned CW = cnt_width(W);

  cmp_state_t  state;
  logic [W-1:0] sa;
  logic [W-1:0] sb;
  logic [CW-1:0] cnt;
  cmp_result_t res_q;
  cmp_result_t cmp_res_c;

  logic start_c;
  logic cmp_rst_c;
  logic shift_en_c;
  logic finish_c;

  assign start_c    = (state == IDLE) && up_valid && up_ready;
  assign cmp_rst_c  = rst | start_c;
  assign shift_en_c = (state == SHIFT);
  assign finish_c   = shift_en_c && ((cnt == '0) || (EARLY_EXIT && !cmp_res_c.eq));

  serial_comparator_most_significant_first u_cmp (
    .clk      (clk),
    .rst      (cmp_rst_c),
    .en       (shift_en_c),
    .a        (sa[W-1]),
    .b        (sb[W-1]),
    .result_c (cmp_res_c)
  );

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      up_ready   <= 1'b1;
      down_valid <= 1'b0;
      busy       <= 1'b0;
      cnt        <= '0;
      sa         <= '0;
      sb         <= '0;
      res_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_c) begin
            sa       <= up_a;
            sb       <= up_b;
            cnt      <= CW'(W - 1);
            state    <= SHIFT;
            up_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SHIFT: begin
          sa <= sa << 1;
          sb <= sb << 1;
          if (finish_c) begin
            res_q      <= cmp_res_c;
            state      <= DONE;
            down_valid <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          if (down_ready) begin
            res_q      <= '0;
            down_valid <= 1'b0;
            up_ready   <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          up_ready   <= 1'b1;
          down_valid <= 1'b0;
          busy       <= 1'b0;
          res_q      <= '0;
        end
      endcase
    end
  end

  assign down_less    = res_q.less;
  assign down_eq      = res_q.eq;
  assign down_greater = res_q.greater;

endmodule

// File: tb/tb_serial_compare_controller.sv
// Bench for serial_compare_controller: three configurations (W=8/EE=0, W=8/EE=1, W=1/EE=0)
// checked every cycle against a transaction-level model plus directed literal checks.
module tb_serial_compare_controller;

  localparam logic [2:0] R_NONE = 3'b000;
  localparam logic [2:0] R_LESS = 3'b100;
  localparam logic [2:0] R_EQ   = 3'b010;
  localparam logic [2:0] R_GT   = 3'b001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       up_valid[3];
  logic       up_ready[3];
  logic [7:0] up_a[3];
  logic [7:0] up_b[3];
  logic       down_valid[3];
  logic       down_ready[3];
  logic       down_less[3];
  logic       down_eq[3];
  logic       down_greater[3];
  logic       busy[3];

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  serial_compare_controller #(.W(8), .EARLY_EXIT(1'b0)) u_dut0 (
    .clk(clk), .rst(rst),
    .up_valid(up_valid[0]), .up_ready(up_ready[0]), .up_a(up_a[0]), .up_b(up_b[0]),
    .down_valid(down_valid[0]), .down_ready(down_ready[0]),
    .down_less(down_less[0]), .down_eq(down_eq[0]), .down_greater(down_greater[0]),
    .busy(busy[0])
  );

  serial_compare_controller #(.W(8), .EARLY_EXIT(1'b1)) u_dut1 (
    .clk(clk), .rst(rst),
    .up_valid(up_valid[1]), .up_ready(up_ready[1]), .up_a(up_a[1]), .up_b(up_b[1]),
    .down_valid(down_valid[1]), .down_ready(down_ready[1]),
    .down_less(down_less[1]), .down_eq(down_eq[1]), .down_greater(down_greater[1]),
    .busy(busy[1])
  );

  serial_compare_controller #(.W(1), .EARLY_EXIT(1'b0)) u_dut2 (
    .clk(clk), .rst(rst),
    .up_valid(up_valid[2]), .up_ready(up_ready[2]), .up_a(up_a[2][0:0]), .up_b(up_b[2][0:0]),
    .down_valid(down_valid[2]), .down_ready(down_ready[2]),
    .down_less(down_less[2]), .down_eq(down_eq[2]), .down_greater(down_greater[2]),
    .busy(busy[2])
  );

  function automatic int cfg_w(input int i);
    return (i == 2) ? 1 : 8;
  endfunction

  function automatic bit cfg_ee(input int i);
    return (i == 1);
  endfunction

  // Reference: plain unsigned comparison of the low w bits.
  function automatic logic [2:0] ref_result(input logic [7:0] a, input logic [7:0] b, input int w);
    int ma;
    int mb;
    ma = int'(a) & ((1 << w) - 1);
    mb = int'(b) & ((1 << w) - 1);
    if (ma < mb) return R_LESS;
    if (ma > mb) return R_GT;
    return R_EQ;
  endfunction

  // Reference: accept-to-valid latency in cycles.
  function automatic int ref_latency(input logic [7:0] a, input logic [7:0] b, input int w, input bit ee);
    if (!ee) return w + 1;
    for (int k = 0; k < w; k++)
      if (a[w-1-k] != b[w-1-k]) return k + 2;
    return w + 1;
  endfunction

  function automatic logic [2:0] dut_res(input int i);
    return {down_less[i], down_eq[i], down_greater[i]};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: ready/idle, countdown to result, result pending for consumer.
  bit         m_ready[3];
  bit         m_valid[3];
  logic [2:0] m_res[3];
  logic [2:0] m_pend[3];
  int         m_wait[3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_ready[i] = 1'b1;
        m_valid[i] = 1'b0;
        m_res[i]   = R_NONE;
        m_wait[i]  = 0;
      end else if (m_ready[i] && up_valid[i]) begin
        m_ready[i] = 1'b0;
        m_pend[i]  = ref_result(up_a[i], up_b[i], cfg_w(i));
        m_wait[i]  = ref_latency(up_a[i], up_b[i], cfg_w(i), cfg_ee(i)) - 1;
      end else if (m_wait[i] > 0) begin
        m_wait[i]--;
        if (m_wait[i] == 0) begin
          m_valid[i] = 1'b1;
          m_res[i]   = m_pend[i];
        end
      end else if (m_valid[i] && down_ready[i]) begin
        m_valid[i] = 1'b0;
        m_res[i]   = R_NONE;
        m_ready[i] = 1'b1;
      end
    end
  end

  // Per-cycle compare of every instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("model%0d up_ready", i), 8'(up_ready[i]), 8'(m_ready[i]));
        check($sformatf("model%0d busy", i), 8'(busy[i]), 8'(!m_ready[i]));
        check($sformatf("model%0d down_valid", i), 8'(down_valid[i]), 8'(m_valid[i]));
        check($sformatf("model%0d result", i), 8'(dut_res(i)), 8'(m_res[i]));
      end
    end
  end

  task automatic accept(input int i, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    check($sformatf("inst%0d ready_before_accept", i), 8'(up_ready[i]), 8'd1);
    up_valid[i] = 1'b1;
    up_a[i]     = a;
    up_b[i]     = b;
    @(posedge clk);
    #1;
    up_valid[i] = 1'b0;
    up_a[i]     = ~a;
    up_b[i]     = ~b;
  endtask

  task automatic await_result(input int i, input int exp_lat, input logic [2:0] exp_res, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!down_valid[i] && n < 40);
    check({name, " latency"}, 8'(n), 8'(exp_lat));
    check({name, " result"}, 8'(dut_res(i)), 8'(exp_res));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      up_valid[i]   = 1'b0;
      down_ready[i] = 1'b1;
      up_a[i]       = 8'h00;
      up_b[i]       = 8'h00;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset%0d up_ready", i), 8'(up_ready[i]), 8'd1);
      check($sformatf("reset%0d down_valid", i), 8'(down_valid[i]), 8'd0);
      check($sformatf("reset%0d busy", i), 8'(busy[i]), 8'd0);
      check($sformatf("reset%0d result", i), 8'(dut_res(i)), 8'(R_NONE));
    end
    rst    = 1'b0;
    chk_en = 1'b1;

    // Full-length compare, result held one cycle with consumer ready.
    accept(0, 8'h64, 8'h62);
    await_result(0, 9, R_GT, "t1_gt");
    @(negedge clk);
    check("t1 valid_one_cycle", 8'(down_valid[0]), 8'd0);
    check("t1 ready_again", 8'(up_ready[0]), 8'd1);

    // Equal operands take the full length in both modes.
    accept(0, 8'hA5, 8'hA5);
    await_result(0, 9, R_EQ, "t2_eq_ee0");
    accept(1, 8'hA5, 8'hA5);
    await_result(1, 9, R_EQ, "t2_eq_ee1");

    // Early exit at MSB, at LSB, and in the middle (bit 2 differs -> k=5).
    accept(1, 8'h00, 8'h80);
    await_result(1, 2, R_LESS, "t3_msb");
    accept(1, 8'h41, 8'h40);
    await_result(1, 9, R_GT, "t3_lsb");
    accept(1, 8'h64, 8'h62);
    await_result(1, 7, R_GT, "t3_mid");

    // Consumer stall, then handshake with the next pair already waiting.
    down_ready[0] = 1'b0;
    accept(0, 8'h30, 8'h31);
    await_result(0, 9, R_LESS, "t4_less");
    up_valid[0] = 1'b1;
    up_a[0]     = 8'h05;
    up_b[0]     = 8'h05;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t4 hold_valid", 8'(down_valid[0]), 8'd1);
      check("t4 hold_result", 8'(dut_res(0)), 8'(R_LESS));
      check("t4 hold_up_ready", 8'(up_ready[0]), 8'd0);
    end
    down_ready[0] = 1'b1;
    @(negedge clk);
    check("t4 ready_after_handshake", 8'(up_ready[0]), 8'd1);
    check("t4 valid_dropped", 8'(down_valid[0]), 8'd0);
    @(posedge clk);
    #1;
    up_valid[0] = 1'b0;
    up_a[0]     = 8'hFF;
    up_b[0]     = 8'h00;
    await_result(0, 9, R_EQ, "t4_next");

    // Reset in the third SHIFT cycle drops the compare.
    accept(0, 8'hF0, 8'h0F);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5 down_valid", 8'(down_valid[0]), 8'd0);
    check("t5 up_ready", 8'(up_ready[0]), 8'd1);
    check("t5 busy", 8'(busy[0]), 8'd0);
    check("t5 result", 8'(dut_res(0)), 8'(R_NONE));
    rst = 1'b0;
    accept(0, 8'h10, 8'h20);
    await_result(0, 9, R_LESS, "t5_after_rst");

    // W=1 back-to-back: each accept lands 3 cycles after the previous one.
    accept(2, 8'h01, 8'h00);
    await_result(2, 2, R_GT, "t6_gt");
    accept(2, 8'h00, 8'h00);
    await_result(2, 2, R_EQ, "t6_eq");
    accept(2, 8'h00, 8'h01);
    await_result(2, 2, R_LESS, "t6_less");

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
